mem_wb_stage: RTL
=================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width; legal values 32 and 64.
REQ-002 SHALL have parameter RA_W, default 5, register-index width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, EX/MEM entry valid.
REQ-006 SHALL have port in_ready, output, 1, stage accepts an entry this cycle.
REQ-007 SHALL have port flush, input, 1, squash the current or incoming op.
REQ-008 SHALL have ports regwrite, memread and memwrite, input, 1 each, control bits.
REQ-009 SHALL have port wb_sel, input, 2, writeback source: 00 ALU, 01 load, 10 link, 11 target.
REQ-010 SHALL have port funct3, input, 3, access size and sign.
REQ-011 SHALL have port rd, input, RA_W, destination register.
REQ-012 SHALL have ports alu_result, store_data, link_addr and target_addr, input, XLEN each; alu_result is also the memory address.
REQ-013 SHALL have ports dmem_req, output, 1; dmem_we, output, 1; dmem_addr, output, XLEN; dmem_wdata, output, XLEN; and dmem_be, output, XLEN/8.
REQ-014 SHALL have ports dmem_gnt, input, 1; dmem_rvalid, input, 1; and dmem_rdata, input, XLEN.
REQ-015 SHALL have ports wb_valid, output, 1; wb_regwrite, output, 1; wb_rd, output, RA_W; wb_data, output, XLEN; and wb_misalign, output, 1.

Function
REQ-016 SHALL implement an FSM with states IDLE, REQ and WAIT; in_ready SHALL be 1 only in IDLE.
REQ-017 IDLE, in_valid=1, no memread/memwrite, flush=0: the op SHALL retire the next cycle (1-cycle latency).
REQ-018 IDLE, in_valid=1, memread or memwrite, flush=0: the stage SHALL capture all inputs and move to REQ.
REQ-019 In REQ: dmem_req SHALL be 1 and addr/we/wdata/be SHALL stay stable until dmem_gnt=1. On grant, a store SHALL retire the next cycle and return to IDLE; a load SHALL move to WAIT.
REQ-020 In WAIT, on dmem_rvalid=1: the load SHALL be extracted, retire the next cycle, and return to IDLE.
REQ-021 Retire SHALL pulse wb_valid for exactly one cycle; wb_regwrite/wb_rd/wb_data SHALL update only on retire and hold otherwise.
REQ-022 wb_regwrite SHALL equal regwrite AND (rd!=0); stores SHALL have regwrite=0.
REQ-023 funct3[1:0] encodes size: 00 byte, 01 half, 10 word, 11 dword (XLEN=64 only; word when XLEN=32). The offset is addr[log2(XLEN/8)-1:0].
REQ-024 dmem_be SHALL be the size mask shifted left by the offset; dmem_wdata SHALL be store_data replicated across all size-aligned lanes.
REQ-025 Loads SHALL select the lane at the offset; funct3[2]=0 SHALL sign-extend and funct3[2]=1 SHALL zero-extend to XLEN.
REQ-026 wb_data SHALL be: 00 alu_result, 01 extracted load, 10 link_addr, 11 target_addr.
REQ-027 flush in IDLE SHALL drop the incoming op with no wb_valid.
REQ-028 flush in REQ without grant SHALL drop dmem_req next cycle and return to IDLE.
REQ-029 flush in REQ coincident with grant SHALL let the memory transaction complete but suppress wb_valid.
REQ-030 flush in WAIT (or pending from REQ) SHALL stay in WAIT until rvalid, then discard the data with no wb_valid.

Reset
REQ-031 rst=0 SHALL immediately force IDLE, dmem_req=0, dmem_we=0, dmem_be=0, wb_valid=0, wb_regwrite=0, wb_misalign=0, and wb_rd/wb_data/dmem_addr/dmem_wdata=0, regardless of clock.
REQ-032 A memory response arriving after reset abandons an access SHALL be ignored.

Configuration
REQ-033 With MEM_MISALIGN_TRAP_EN defined, an access whose offset is not a multiple of its size SHALL NOT assert dmem_req; it SHALL retire after 1 cycle with wb_misalign=1 and wb_regwrite=0.
REQ-034 Without MEM_MISALIGN_TRAP_EN, wb_misalign SHALL be tied 0 and the offset SHALL be truncated to size alignment before be/lane selection.

Verification
REQ-035 ALU op (wb_sel=00, alu_result=A5A5A5A5, rd=21, regwrite=1) -> next cycle wb_valid=1, wb_data=A5A5A5A5, wb_rd=21, wb_regwrite=1.
REQ-036 LB at 0x103, gnt 2 cycles late, rvalid 3 cycles after grant with rdata=80FFFFFF -> wb_data=FFFFFF80; in_ready=0 throughout.
REQ-037 SH at 0x102 with store_data=0000BEEF -> dmem_be=1100, dmem_wdata=BEEFBEEF, wb_valid=1, wb_regwrite=0.
REQ-038 LW with flush asserted in WAIT -> rvalid consumed, no wb_valid, in_ready=1 the cycle after rvalid.
REQ-039 rst=0 mid-REQ -> dmem_req=0 and in_ready=1 before the next clock edge.
REQ-040 MEM_MISALIGN_TRAP_EN defined, LW at 0x102 -> dmem_req stays 0; next cycle wb_valid=1, wb_misalign=1.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: issues loads/stores on a req/gnt/rvalid data bus and
// retires results to writeback. Optional build macro: MEM_MISALIGN_TRAP_EN.
module mem_wb_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic              regwrite,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [1:0]        wb_sel,
    input  logic [2:0]        funct3,
    input  logic [RA_W-1:0]   rd,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   store_data,
    input  logic [XLEN-1:0]   link_addr,
    input  logic [XLEN-1:0]   target_addr,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [XLEN/8-1:0] dmem_be,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              wb_valid,
    output logic              wb_regwrite,
    output logic [RA_W-1:0]   wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              wb_misalign
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t state;

    // Size code 11 (dword) collapses to word on a 32-bit datapath.
    function automatic logic [1:0] size_lg(input logic [1:0] f);
        return (XLEN == 32 && f == 2'b11) ? 2'b10 : f;
    endfunction

    function automatic logic [OW-1:0] align_off(input logic [OW-1:0] off, input logic [1:0] lg);
        logic [OW-1:0] m;
        m = '1;
        m = m << lg;
        return off & m;
    endfunction

    function automatic logic [NB-1:0] byte_en(input logic [OW-1:0] off, input logic [1:0] lg);
        logic [NB-1:0] m;
        m = '1;
        m = ~(m << (1 << lg));
        return m << off;
    endfunction

    function automatic logic [XLEN-1:0] replicate(input logic [XLEN-1:0] d, input logic [1:0] lg);
        logic [XLEN-1:0] w;
        case (lg)
            2'd0:    w = {NB{d[7:0]}};
            2'd1:    w = {(NB/2){d[15:0]}};
            2'd2:    w = {(NB/4){d[31:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Shift the addressed lane down, then mask and sign/zero fill above it.
    function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] d, input logic [OW-1:0] off,
                                                input logic [1:0] lg, input logic uns);
        logic [XLEN-1:0] s, keep;
        logic            msb;
        s    = d >> {off, 3'b000};
        keep = '1;
        keep = ~(keep << (8 << lg));
        case (lg)
            2'd0:    msb = s[7];
            2'd1:    msb = s[15];
            2'd2:    msb = s[31];
            default: msb = s[XLEN-1];
        endcase
        return (s & keep) | ({XLEN{msb & ~uns}} & ~keep);
    endfunction

    function automatic logic [XLEN-1:0] wb_mux(input logic [1:0] sel, input logic [XLEN-1:0] alu,
                                               input logic [XLEN-1:0] ld, input logic [XLEN-1:0] lnk,
                                               input logic [XLEN-1:0] tgt);
        case (sel)
            2'b00:   return alu;
            2'b01:   return ld;
            2'b10:   return lnk;
            default: return tgt;
        endcase
    endfunction

    logic [1:0]    in_lg;
    logic [OW-1:0] in_off, in_off_al;
    logic          in_mem, mis_trap, go_mem;

    always_comb begin
        in_lg     = size_lg(funct3[1:0]);
        in_off    = alu_result[OW-1:0];
        in_off_al = align_off(in_off, in_lg);
        in_mem    = memread | memwrite;
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis_trap = in_mem & (in_off_al != in_off);
`else
    assign mis_trap = 1'b0;
`endif
    assign go_mem   = in_mem & ~mis_trap;
    assign in_ready = (state == IDLE);

    logic [1:0]      lg_q, sel_q;
    logic [OW-1:0]   off_q;
    logic            uns_q, is_load_q, rw_q, kill_q;
    logic [RA_W-1:0] rd_q;
    logic [XLEN-1:0] link_q, tgt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_be     <= '0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            wb_misalign <= 1'b0;
            lg_q        <= '0;
            sel_q       <= '0;
            off_q       <= '0;
            uns_q       <= 1'b0;
            is_load_q   <= 1'b0;
            rw_q        <= 1'b0;
            kill_q      <= 1'b0;
            rd_q        <= '0;
            link_q      <= '0;
            tgt_q       <= '0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: if (in_valid && !flush) begin
                    if (go_mem) begin
                        state      <= REQ;
                        dmem_req   <= 1'b1;
                        dmem_we    <= memwrite;
                        dmem_addr  <= alu_result;
                        dmem_wdata <= replicate(store_data, in_lg);
                        dmem_be    <= byte_en(in_off_al, in_lg);
                        lg_q       <= in_lg;
                        off_q      <= in_off_al;
                        uns_q      <= funct3[2];
                        is_load_q  <= ~memwrite;
                        rw_q       <= regwrite & (rd != '0) & ~memwrite;
                        rd_q       <= rd;
                        sel_q      <= wb_sel;
                        link_q     <= link_addr;
                        tgt_q      <= target_addr;
                        kill_q     <= 1'b0;
                    end else begin
                        // Plain ALU op, or a trapped misaligned access.
                        wb_valid    <= 1'b1;
                        wb_regwrite <= regwrite & (rd != '0) & ~mis_trap;
                        wb_rd       <= rd;
                        wb_data     <= wb_mux(wb_sel, alu_result, '0, link_addr, target_addr);
                        wb_misalign <= mis_trap;
                    end
                end
                REQ: if (dmem_gnt) begin
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                    dmem_be  <= '0;
                    if (is_load_q) begin
                        state  <= WAIT;
                        kill_q <= flush;
                    end else begin
                        state <= IDLE;
                        if (!flush) begin
                            wb_valid    <= 1'b1;
                            wb_regwrite <= 1'b0;
                            wb_rd       <= rd_q;
                            wb_data     <= wb_mux(sel_q, dmem_addr, '0, link_q, tgt_q);
                            wb_misalign <= 1'b0;
                        end
                    end
                end else if (flush) begin
                    state    <= IDLE;
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                    dmem_be  <= '0;
                end
                WAIT: if (dmem_rvalid) begin
                    state  <= IDLE;
                    kill_q <= 1'b0;
                    if (!flush && !kill_q) begin
                        wb_valid    <= 1'b1;
                        wb_regwrite <= rw_q;
                        wb_rd       <= rd_q;
                        wb_data     <= wb_mux(sel_q, dmem_addr, extract(dmem_rdata, off_q, lg_q, uns_q),
                                              link_q, tgt_q);
                        wb_misalign <= 1'b0;
                    end
                end else if (flush) begin
                    kill_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
